// File: rtl/axi_lite_req_arbiter.sv
// axi_lite_req_arbiter
//   Shares one AXI-Lite master port between N_REQ local requesters. Each
//   requester presents a complete single-beat read or write command. The block
//   grants round-robin, runs the AXI-Lite channels for that command and then
//   pulses a completion back to the same requester. Only one transaction is
//   ever in flight on the bus.
//
// Ports
//   aclk, areset          clock (rising edge) and synchronous active-high reset
//   req_valid/req_ready   per-requester command valid / one-hot accept pulse
//   req_write             per-requester 1 = write, 0 = read
//   req_addr/wdata/wstrb  packed per-requester command fields (slice i = req i)
//   rsp_valid             one-hot, one-cycle completion pulse
//   rsp_rdata             read data of the last completed read
//   rsp_err               resp[1] of the completed transaction (valid with rsp_valid)
//   busy                  high whenever the sequencer is not idle
//   grant_id              current or last granted requester
//   aw*/w*/b*/ar*/r*      AXI-Lite master channels
module axi_lite_req_arbiter #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int STRB_W = DATA_W / 8,
  localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ-1:0]           req_write,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr,
  input  logic [N_REQ*DATA_W-1:0]    req_wdata,
  input  logic [N_REQ*STRB_W-1:0]    req_wstrb,
  output logic [N_REQ-1:0]           rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_err,
  output logic                       busy,
  output logic [ID_W-1:0]            grant_id,
  output logic                       awvalid,
  output logic [ADDR_W-1:0]          awaddr,
  input  logic                       awready,
  output logic                       wvalid,
  output logic [DATA_W-1:0]          wdata,
  output logic [STRB_W-1:0]          wstrb,
  input  logic                       wready,
  input  logic                       bvalid,
  input  logic [1:0]                 bresp,
  output logic                       bready,
  output logic                       arvalid,
  output logic [ADDR_W-1:0]          araddr,
  input  logic                       arready,
  input  logic                       rvalid,
  input  logic [DATA_W-1:0]          rdata,
  input  logic [1:0]                 rresp,
  output logic                       rready
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_REQ  = 3'd1;
  localparam logic [2:0] WR_RESP = 3'd2;
  localparam logic [2:0] RD_REQ  = 3'd3;
  localparam logic [2:0] RD_RESP = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  localparam logic [ID_W:0]   N_REQ_W = (ID_W + 1)'(N_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

  logic [2:0]      state_reg;
  logic [ID_W-1:0] rr_ptr_reg;

  // Per-requester views of the packed command buses.
  logic [ADDR_W-1:0] addr_arr  [N_REQ];
  logic [DATA_W-1:0] wdata_arr [N_REQ];
  logic [STRB_W-1:0] wstrb_arr [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    assign wstrb_arr[gi] = req_wstrb[gi*STRB_W +: STRB_W];
  end

  // Round-robin scan: first valid requester at or after rr_ptr, wrapping.
  logic            found;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W:0]   scan_idx;

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr_reg} + (ID_W + 1)'(k);
      if (scan_idx >= N_REQ_W) begin
        scan_idx = scan_idx - N_REQ_W;
      end
      if (!found && req_valid[scan_idx[ID_W-1:0]]) begin
        found     = 1'b1;
        grant_idx = scan_idx[ID_W-1:0];
      end
    end
  end

  assign req_ready = (state_reg == IDLE && found) ? (N_REQ'(1) << grant_idx) : '0;
  assign rsp_valid = (state_reg == DONE) ? (N_REQ'(1) << grant_id) : '0;
  assign busy      = (state_reg != IDLE);

  // Only resp[1] distinguishes OKAY/EXOKAY from SLVERR/DECERR.
  logic unused_resp_bits;
  assign unused_resp_bits = ^{bresp[0], rresp[0]};

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      grant_id   <= '0;
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      awaddr     <= '0;
      araddr     <= '0;
      wdata      <= '0;
      wstrb      <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (found) begin
            grant_id   <= grant_idx;
            rr_ptr_reg <= (grant_idx == LAST_ID) ? '0 : grant_idx + ID_W'(1);
            awaddr     <= addr_arr[grant_idx];
            araddr     <= addr_arr[grant_idx];
            wdata      <= wdata_arr[grant_idx];
            wstrb      <= wstrb_arr[grant_idx];
            if (req_write[grant_idx]) begin
              awvalid   <= 1'b1;
              wvalid    <= 1'b1;
              state_reg <= WR_REQ;
            end else begin
              arvalid   <= 1'b1;
              state_reg <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          // AW and W complete independently; move on once neither is pending.
          awvalid <= awvalid & ~awready;
          wvalid  <= wvalid & ~wready;
          if ((!awvalid || awready) && (!wvalid || wready)) begin
            bready    <= 1'b1;
            state_reg <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bvalid) begin
            bready    <= 1'b0;
            rsp_err   <= bresp[1];
            state_reg <= DONE;
          end
        end
        RD_REQ: begin
          if (arready) begin
            arvalid   <= 1'b0;
            rready    <= 1'b1;
            state_reg <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (rvalid) begin
            rready    <= 1'b0;
            rsp_rdata <= rdata;
            rsp_err   <= rresp[1];
            state_reg <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
